// File: rtl/riscv_test_monitor_pkg.sv
// Shared definitions for the RISC-V end-of-test monitor: the monitor state
// encoding, the default register indices of the test harness convention, and
// the register-file port geometry.
package riscv_test_pkg;

    // Default register indices used by the riscv-tests style harness.
    localparam int TEST_DONE_REG   = 26;
    localparam int TEST_RESULT_REG = 27;
    localparam int TEST_NUM_REG    = 3;

    // Register-file geometry of one write-back port.
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_SETTLE,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } test_mon_state_t;

    // True in the states that hold a final verdict.
    function automatic logic is_verdict(input test_mon_state_t st);
        return (st == ST_PASS) || (st == ST_FAIL) || (st == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/riscv_test_monitor_shadow.sv
// test_mon_shadow: shadow copy of a single architectural register, built by
// snooping NUM_WB register-file write-back ports. When several ports write the
// register in the same cycle, the highest port index (youngest in program
// order) wins. Writes to x0 never land, so REG_IDX = 0 yields a constant 0.
module test_mon_shadow
    import riscv_test_pkg::*;
#(
    parameter int NUM_WB  = 1,
    parameter int REG_IDX = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         capture,
    input  logic [NUM_WB-1:0]            wb_we,
    input  logic [REG_ADDR_W*NUM_WB-1:0] wb_addr,
    input  logic [REG_DATA_W*NUM_WB-1:0] wb_data,
    output logic [REG_DATA_W-1:0]        value
);

    localparam logic [REG_ADDR_W-1:0] IDX      = REG_ADDR_W'(REG_IDX);
    localparam bit                    WRITABLE = (REG_IDX != 0);

    logic                  hit;
    logic [REG_DATA_W-1:0] hit_data;

    // Resolve which port (if any) writes this register; later ports override earlier ones.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        hit      = 1'b0;
        hit_data = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (WRITABLE && wb_we[k] &&
                (wb_addr[REG_ADDR_W*k +: REG_ADDR_W] == IDX)) begin
                hit      = 1'b1;
                hit_data = wb_data[REG_DATA_W*k +: REG_DATA_W];
            end
        end
    end

    // Shadow register: cleared on reset or re-arm, updated only while capturing.
    always_ff @(posedge clk) begin
        // NOTE: the shadow is a plain flop with an explicit reset value, so it must be cleared here; non-blocking keeps every flop sampling pre-edge values.
        if (rst || clear) begin
            value <= '0;
        end else if (capture && hit) begin
            value <= hit_data;
        end
    end

endmodule

// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: end-of-test monitor for the RISC-V SoC.
// Snoops the register-file write-back ports, shadows the done, result and
// test-number registers, waits SETTLE_CYCLES after done is seen and then
// latches a sticky pass/fail verdict together with cycle and retired
// instruction counts.
// Optional watchdog: define RISCV_TEST_MONITOR_TIMEOUT_EN to make RUN exit to
// TIMEOUT after TIMEOUT_CYCLES; without it timeout_o is tied to 0.
module riscv_test_monitor
    import riscv_test_pkg::*;
#(
    parameter int NUM_WB         = 1,
    parameter int DONE_REG       = TEST_DONE_REG,
    parameter int RESULT_REG     = TEST_RESULT_REG,
    parameter int TESTNUM_REG    = TEST_NUM_REG,
    parameter int SETTLE_CYCLES  = 5,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [NUM_WB-1:0]            wb_we_i,
    input  logic [REG_ADDR_W*NUM_WB-1:0] wb_addr_i,
    input  logic [REG_DATA_W*NUM_WB-1:0] wb_data_i,
    input  logic [NUM_WB-1:0]            retire_i,
    output logic                         done_o,
    output logic                         pass_o,
    output logic                         fail_o,
    output logic                         timeout_o,
    output logic [REG_DATA_W-1:0]        testnum_o,
    output logic [CNT_W-1:0]             cycle_cnt_o,
    output logic [CNT_W-1:0]             instret_o
);

    localparam int                  SETTLE_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam int                  POP_W       = $clog2(NUM_WB + 1);

    test_mon_state_t       state;
    logic [SETTLE_W-1:0]   settle_cnt;
    logic [CNT_W-1:0]      cycle_cnt;
    logic [CNT_W-1:0]      instret;
    logic [POP_W-1:0]      retire_cnt;
    logic [CNT_W:0]        instret_sum;
    logic [REG_DATA_W-1:0] shadow_done;
    logic [REG_DATA_W-1:0] shadow_result;
    logic [REG_DATA_W-1:0] shadow_testnum;
    logic                  arm;
    logic                  active;

    // Re-arming is possible from IDLE and from any verdict state; RUN and SETTLE ignore start_i.
    assign arm    = start_i && ((state == ST_IDLE) || is_verdict(state));
    assign active = (state == ST_RUN) || (state == ST_SETTLE);

`ifdef RISCV_TEST_MONITOR_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic timeout_q;
    logic timeout_hit;

    // The count reaches TIMEOUT_CYCLES on the same edge that enters TIMEOUT.
    assign timeout_hit = (cycle_cnt >= TIMEOUT_LAST);
    assign timeout_o   = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    test_mon_shadow #(.NUM_WB(NUM_WB), .REG_IDX(DONE_REG)) u_shadow_done (
        .clk     (clk),
        .rst     (rst),
        .clear   (arm),
        .capture (active),
        .wb_we   (wb_we_i),
        .wb_addr (wb_addr_i),
        .wb_data (wb_data_i),
        .value   (shadow_done)
    );

    test_mon_shadow #(.NUM_WB(NUM_WB), .REG_IDX(RESULT_REG)) u_shadow_result (
        .clk     (clk),
        .rst     (rst),
        .clear   (arm),
        .capture (active),
        .wb_we   (wb_we_i),
        .wb_addr (wb_addr_i),
        .wb_data (wb_data_i),
        .value   (shadow_result)
    );

    test_mon_shadow #(.NUM_WB(NUM_WB), .REG_IDX(TESTNUM_REG)) u_shadow_testnum (
        .clk     (clk),
        .rst     (rst),
        .clear   (arm),
        .capture (active),
        .wb_we   (wb_we_i),
        .wb_addr (wb_addr_i),
        .wb_data (wb_data_i),
        .value   (shadow_testnum)
    );

    // Number of instructions retired this cycle across all ports.
    always_comb begin
        retire_cnt = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            retire_cnt = retire_cnt + POP_W'(retire_i[k]);
        end
    end

    // One extra bit catches the carry so the counter can saturate instead of wrapping.
    assign instret_sum = {1'b0, instret} + (CNT_W + 1)'(retire_cnt);

    // Cycle and instret counters: cleared on arm, saturating while RUN or SETTLE.
    always_ff @(posedge clk) begin
        if (rst || arm) begin
            cycle_cnt <= '0;
            instret   <= '0;
        end else if (active) begin
            if (cycle_cnt != '1) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            instret <= instret_sum[CNT_W] ? '1 : instret_sum[CNT_W-1:0];
        end
    end

    // Monitor FSM with registered verdict flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            fail_o     <= 1'b0;
`ifdef RISCV_TEST_MONITOR_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Done is checked first so it wins over a simultaneous timeout.
                    if (shadow_done == REG_DATA_W'(1)) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                    end
`ifdef RISCV_TEST_MONITOR_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state     <= ST_TIMEOUT;
                        done_o    <= 1'b1;
                        timeout_q <= 1'b1;
                    end
`endif
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        done_o <= 1'b1;
                        if (shadow_result == REG_DATA_W'(1)) begin
                            state  <= ST_PASS;
                            pass_o <= 1'b1;
                        end else begin
                            state  <= ST_FAIL;
                            fail_o <= 1'b1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_W'(1);
                    end
                end
                ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                    if (start_i) begin
                        state     <= ST_RUN;
                        done_o    <= 1'b0;
                        pass_o    <= 1'b0;
                        fail_o    <= 1'b0;
`ifdef RISCV_TEST_MONITOR_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign testnum_o   = shadow_testnum;
    assign cycle_cnt_o = cycle_cnt;
    assign instret_o   = instret;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Self-checking bench for riscv_test_monitor (NUM_WB=2, SETTLE_CYCLES=5,
// TIMEOUT_CYCLES=50). Every edge is compared against a behavioural model of
// the monitor; directed table rows and hand-written sequences additionally
// carry hand-derived expectations.
module tb_riscv_test_monitor;

    localparam int NUM_WB  = 2;
    localparam int SETTLE  = 5;
    localparam int TIMEOUT = 50;
    localparam int CNT_W   = 32;
    localparam int R_DONE  = 26;
    localparam int R_RES   = 27;
    localparam int R_TNUM  = 3;
    localparam longint CMAX = (64'd1 << CNT_W) - 1;
`ifdef RISCV_TEST_MONITOR_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  we = '0;
    logic [9:0]  addr = '0;
    logic [63:0] data = '0;
    logic [1:0]  retire = '0;
    logic        done_o, pass_o, fail_o, timeout_o;
    logic [31:0] testnum_o;
    logic [CNT_W-1:0] cycle_cnt_o, instret_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_test_monitor #(
        .NUM_WB(NUM_WB), .DONE_REG(R_DONE), .RESULT_REG(R_RES), .TESTNUM_REG(R_TNUM),
        .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start),
        .wb_we_i(we), .wb_addr_i(addr), .wb_data_i(data), .retire_i(retire),
        .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o),
        .testnum_o(testnum_o), .cycle_cnt_o(cycle_cnt_o), .instret_o(instret_o)
    );

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_reg [32];
    bit          m_running;   // monitor is in RUN or SETTLE
    int          m_settle;    // settle cycles still to go, 0 when not settling
    int          m_verdict;   // 0 none, 1 pass, 2 fail, 3 timeout
    longint      m_cyc, m_inst;

    function automatic void m_clear();
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_cyc = 0; m_inst = 0; m_settle = 0; m_verdict = 0;
    endfunction

    function automatic void model_step();
        logic [31:0] d_seen, r_seen;
        longint      c_seen;
        if (rst) begin
            m_clear(); m_running = 0;
            return;
        end
        if (!m_running) begin
            if (start) begin
                m_clear(); m_running = 1;
            end
            return;
        end
        d_seen = m_reg[R_DONE]; r_seen = m_reg[R_RES]; c_seen = m_cyc;
        m_cyc  = (c_seen + 1 > CMAX) ? CMAX : c_seen + 1;
        m_inst = m_inst + $countones(retire);
        if (m_inst > CMAX) m_inst = CMAX;
        for (int k = 0; k < NUM_WB; k++)
            if (we[k] && addr[5*k +: 5] != 5'd0) m_reg[addr[5*k +: 5]] = data[32*k +: 32];
        if (m_settle > 0) begin
            m_settle--;
            if (m_settle == 0) begin
                m_running = 0;
                m_verdict = (r_seen == 32'd1) ? 1 : 2;
            end
        end else if (d_seen == 32'd1) begin
            m_settle = SETTLE;
        end else if (WD_EN && (c_seen + 1 >= TIMEOUT)) begin
            m_running = 0;
            m_verdict = 3;
        end
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("m_done",    64'(done_o),      64'(m_verdict != 0));
        check("m_pass",    64'(pass_o),      64'(m_verdict == 1));
        check("m_fail",    64'(fail_o),      64'(m_verdict == 2));
        check("m_timeout", 64'(timeout_o),   64'(m_verdict == 3));
        check("m_testnum", 64'(testnum_o),   64'(m_reg[R_TNUM]));
        check("m_cycle",   64'(cycle_cnt_o), 64'(m_cyc));
        check("m_instret", 64'(instret_o),   64'(m_inst));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic drive(input logic [1:0] w, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1, input logic [1:0] r);
        we = w; addr = {a1, a0}; data = {d1, d0}; retire = r;
    endtask

    task automatic idle();
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b00);
    endtask

    task automatic arm();
        idle(); start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic wait_verdict(input int budget);
        idle();
        for (int i = 0; i < budget; i++) begin
            if (done_o) break;
            tick();
        end
        check("wait_verdict", 64'(done_o), 64'd1);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit        rst, start;
        bit [1:0]  we;
        bit [4:0]  a0;
        bit [31:0] d0;
        bit [4:0]  a1;
        bit [31:0] d1;
        bit [1:0]  ret;
        bit        e_done, e_pass, e_fail;
        bit [31:0] e_tnum;
        int        e_cyc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit s, bit [1:0] w, bit [4:0] a0, bit [31:0] d0,
                                bit [4:0] a1, bit [31:0] d1, bit [1:0] ret,
                                bit ed, bit ep, bit ef, bit [31:0] etn, int ec);
        vec_t v;
        v.rst = r; v.start = s; v.we = w; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.ret = ret; v.e_done = ed; v.e_pass = ep; v.e_fail = ef; v.e_tnum = etn; v.e_cyc = ec;
        return v;
    endfunction

    function automatic logic [4:0] pick_addr();
        case ($urandom_range(0, 4))
            0: return 5'd0;
            1: return 5'd3;
            2: return 5'd26;
            3: return 5'd27;
            default: return 5'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] pick_data();
        case ($urandom_range(0, 3))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'd2;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_clear(); m_running = 0;

        // Pass case: x26=1 written in cycle 10, verdict visible in cycle 17.
        //             rst st we     a0     d0     a1     d1     ret    dn ps fl tn  cyc
        tbl.push_back(mk(1, 0, 2'b00, 5'd0,  32'd0, 5'd0,  32'd0, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 2'b00, 5'd0,  32'd0, 5'd0,  32'd0, 2'b00, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2'b01, 5'd3,  32'd2, 5'd0,  32'd0, 2'b01, 0, 0, 0, 2, 1));
        tbl.push_back(mk(0, 0, 2'b01, 5'd27, 32'd1, 5'd0,  32'd0, 2'b01, 0, 0, 0, 2, 2));
        tbl.push_back(mk(0, 0, 2'b00, 5'd0,  32'd0, 5'd0,  32'd0, 2'b01, 0, 0, 0, 2, 3));
        tbl.push_back(mk(0, 1, 2'b00, 5'd0,  32'd0, 5'd0,  32'd0, 2'b00, 0, 0, 0, 2, 4));
        tbl.push_back(mk(0, 0, 2'b10, 5'd0,  32'd0, 5'd26, 32'd2, 2'b00, 0, 0, 0, 2, 5));
        tbl.push_back(mk(0, 0, 2'b00, 5'd0,  32'd0, 5'd0,  32'd0, 2'b00, 0, 0, 0, 2, 6));
        tbl.push_back(mk(0, 0, 2'b01, 5'd0,  32'd1, 5'd0,  32'd0, 2'b00, 0, 0, 0, 2, 7));
        tbl.push_back(mk(0, 0, 2'b00, 5'd0,  32'd0, 5'd0,  32'd0, 2'b00, 0, 0, 0, 2, 8));
        tbl.push_back(mk(0, 0, 2'b01, 5'd26, 32'd1, 5'd0,  32'd0, 2'b00, 0, 0, 0, 2, 9));
        tbl.push_back(mk(0, 0, 2'b00, 5'd0,  32'd0, 5'd0,  32'd0, 2'b00, 0, 0, 0, 2, 10));
        tbl.push_back(mk(0, 0, 2'b00, 5'd0,  32'd0, 5'd0,  32'd0, 2'b11, 0, 0, 0, 2, 11));
        tbl.push_back(mk(0, 1, 2'b00, 5'd0,  32'd0, 5'd0,  32'd0, 2'b00, 0, 0, 0, 2, 12));
        tbl.push_back(mk(0, 0, 2'b00, 5'd0,  32'd0, 5'd0,  32'd0, 2'b00, 0, 0, 0, 2, 13));
        tbl.push_back(mk(0, 0, 2'b00, 5'd0,  32'd0, 5'd0,  32'd0, 2'b00, 0, 0, 0, 2, 14));
        tbl.push_back(mk(0, 0, 2'b00, 5'd0,  32'd0, 5'd0,  32'd0, 2'b00, 1, 1, 0, 2, 15));
        tbl.push_back(mk(0, 0, 2'b00, 5'd0,  32'd0, 5'd0,  32'd0, 2'b01, 1, 1, 0, 2, 15));
        tbl.push_back(mk(0, 0, 2'b01, 5'd3,  32'd9, 5'd0,  32'd0, 2'b00, 1, 1, 0, 2, 15));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; start = tbl[i].start;
            drive(tbl[i].we, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1, tbl[i].ret);
            tick();
            check($sformatf("tbl%0d_done", i), 64'(done_o),      64'(tbl[i].e_done));
            check($sformatf("tbl%0d_pass", i), 64'(pass_o),      64'(tbl[i].e_pass));
            check($sformatf("tbl%0d_fail", i), 64'(fail_o),      64'(tbl[i].e_fail));
            check($sformatf("tbl%0d_tnum", i), 64'(testnum_o),   64'(tbl[i].e_tnum));
            check($sformatf("tbl%0d_cyc",  i), 64'(cycle_cnt_o), 64'(tbl[i].e_cyc));
        end
        rst = 1'b0; start = 1'b0;

        // Re-arm from PASS: verdict and counters clear on the next cycle.
        arm();
        check("rearm_done", 64'(done_o), 64'd0);
        check("rearm_pass", 64'(pass_o), 64'd0);
        check("rearm_tnum", 64'(testnum_o), 64'd0);
        check("rearm_cyc",  64'(cycle_cnt_o), 64'd0);

        // Fail case: result 0, test number 5.
        drive(2'b01, 5'd3, 32'd5, 5'd0, 32'd0, 2'b00); tick();
        drive(2'b01, 5'd27, 32'd0, 5'd0, 32'd0, 2'b00); tick();
        drive(2'b01, 5'd26, 32'd1, 5'd0, 32'd0, 2'b00); tick();
        wait_verdict(20);
        check("failcase_fail", 64'(fail_o), 64'd1);
        check("failcase_pass", 64'(pass_o), 64'd0);
        check("failcase_tnum", 64'(testnum_o), 64'd5);

        // Late result: x27=1 two cycles after done, inside the settle window.
        arm();
        drive(2'b01, 5'd26, 32'd1, 5'd0, 32'd0, 2'b00); tick();
        idle(); tick();
        drive(2'b01, 5'd27, 32'd1, 5'd0, 32'd0, 2'b00); tick();
        wait_verdict(20);
        check("late_pass", 64'(pass_o), 64'd1);

        // Port priority: port1 writing x27=0 overrides port0 writing x27=1.
        arm();
        drive(2'b11, 5'd27, 32'd1, 5'd27, 32'd0, 2'b11); tick();
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b11); tick(); tick(); tick();
        drive(2'b01, 5'd26, 32'd1, 5'd0, 32'd0, 2'b00); tick();
        wait_verdict(20);
        check("prio_fail", 64'(fail_o), 64'd1);
        check("prio_instret_ge8", 64'(instret_o >= 8), 64'd1);

        // Watchdog.
        arm();
`ifdef RISCV_TEST_MONITOR_TIMEOUT_EN
        wait_verdict(80);
        check("wd_timeout", 64'(timeout_o), 64'd1);
        check("wd_cycle", 64'(cycle_cnt_o), 64'd50);
        arm();
        check("wd_rearm_done", 64'(done_o), 64'd0);
        check("wd_rearm_timeout", 64'(timeout_o), 64'd0);
        check("wd_rearm_cyc", 64'(cycle_cnt_o), 64'd0);
`else
        repeat (70) tick();
        check("nowd_timeout", 64'(timeout_o), 64'd0);
        check("nowd_done", 64'(done_o), 64'd0);
        check("nowd_cycle", 64'(cycle_cnt_o), 64'd70);
`endif

        // Reset in SETTLE, then a clean pass.
        rst = 1'b1; tick(); rst = 1'b0;
        arm();
        drive(2'b01, 5'd3, 32'd7, 5'd0, 32'd0, 2'b01); tick();
        drive(2'b01, 5'd26, 32'd1, 5'd0, 32'd0, 2'b01); tick();
        idle(); tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_pass", 64'(pass_o), 64'd0);
        check("rst_fail", 64'(fail_o), 64'd0);
        check("rst_tnum", 64'(testnum_o), 64'd0);
        check("rst_cyc",  64'(cycle_cnt_o), 64'd0);
        check("rst_inst", 64'(instret_o), 64'd0);
        tick();
        check("rst_idle_cyc", 64'(cycle_cnt_o), 64'd0);
        arm();
        drive(2'b01, 5'd27, 32'd1, 5'd0, 32'd0, 2'b00); tick();
        drive(2'b01, 5'd26, 32'd1, 5'd0, 32'd0, 2'b00); tick();
        wait_verdict(20);
        check("post_rst_pass", 64'(pass_o), 64'd1);

        // Randomized traffic at three write densities, checked against the model.
        for (int seg = 0; seg < 3; seg++) begin
            int wprob;
            wprob = (seg == 0) ? 2 : (seg == 1) ? 8 : 40;
            for (int n = 0; n < 1000; n++) begin
                logic [1:0] w;
                rst   = ($urandom_range(0, 299) == 0);
                start = ($urandom_range(0, 39) == 0);
                w[0]  = ($urandom_range(0, wprob - 1) == 0);
                w[1]  = ($urandom_range(0, wprob - 1) == 0);
                drive(w, pick_addr(), pick_data(), pick_addr(), pick_data(), 2'($urandom));
                tick();
            end
        end
        rst = 1'b0; start = 1'b0; idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_test_monitor.md
# riscv_test_monitor

Synthesizable, parametrised end-of-test monitor for the RISC-V SoC. Snoops the core's register-file write-back ports, keeps shadow copies of the done, result and test-number registers, waits a settle window after completion, and issues a sticky pass/fail/timeout verdict with cycle and retired-instruction counts. It sits beside `riscv_core` inside `riscv_soc` (or in a bench harness) and replaces hierarchical register peeking, so FPGA builds and multi-write-port cores self-check the same way.

## Interface
Parameters:
- `NUM_WB`, 1: number of register write-back ports snooped.
- `DONE_REG`, 26: register whose value 1 marks test completion.
- `RESULT_REG`, 27: register whose value 1 marks pass.
- `TESTNUM_REG`, 3: register holding the current test number.
- `SETTLE_CYCLES`, 5: cycles waited after done before sampling the result. Legal range ≥1.
- `TIMEOUT_CYCLES`, 100000: run-cycle limit. Legal range ≥1.
- `CNT_W`, 32: width of the cycle and instret counters.

Ports:
- `clk`, input, 1: single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `start_i`, input, 1: arm or re-arm the monitor.
- `wb_we_i`, input, NUM_WB: per-port write enable.
- `wb_addr_i`, input, 5*NUM_WB: per-port destination register, port k at [5k+4:5k].
- `wb_data_i`, input, 32*NUM_WB: per-port write data.
- `retire_i`, input, NUM_WB: per-port instruction-retired strobe.
- `done_o`, output, 1: verdict valid. Sticky.
- `pass_o`, output, 1: test passed.
- `fail_o`, output, 1: test failed.
- `timeout_o`, output, 1: watchdog expired.
- `testnum_o`, output, 32: shadow TESTNUM_REG, frozen at the verdict.
- `cycle_cnt_o`, output, CNT_W: cycles spent in RUN plus SETTLE.
- `instret_o`, output, CNT_W: instructions retired in RUN plus SETTLE.

## Operation
States are IDLE, RUN, SETTLE, PASS, FAIL and TIMEOUT.
- IDLE: go to RUN on `start_i`. Entering RUN clears the shadows, counters and verdict outputs.
- RUN: go to SETTLE when the shadow DONE equals 1. Otherwise, with the watchdog compiled in, go to TIMEOUT once `cycle_cnt` reaches TIMEOUT_CYCLES.
- SETTLE: count SETTLE_CYCLES cycles, then go to PASS if the shadow RESULT equals 1, otherwise FAIL.
- PASS, FAIL, TIMEOUT: hold the verdict. `start_i` re-arms directly into RUN with a full clear.
- `start_i` is ignored in RUN and SETTLE.

Shadow capture:
- On each cycle, for each port with `wb_we_i[k]`, write `wb_data_i` into the matching shadow.
- Writes to x0 are ignored.
- If several ports write the same register in the same cycle, the highest port index wins (later in program order).
- Capture continues through SETTLE, so late result writes count. It stops in the verdict states.

Counters:
- `cycle_cnt` adds 1 per cycle in RUN and SETTLE.
- `instret` adds popcount(`retire_i`) per cycle in RUN and SETTLE.
- Both saturate at 2^CNT_W−1 and never wrap.

Outputs:
- `done_o` is 1 in PASS, FAIL and TIMEOUT.
- Exactly one of `pass_o`, `fail_o`, `timeout_o` is 1 while `done_o` is 1; all three are 0 otherwise.

## Timing
- Reset (`rst`=1 at a `clk` edge) puts the block in IDLE with every output 0 and every shadow 0. This applies mid-run too: any state returns to IDLE at the next edge.
- Registered outputs: a write-back in cycle N is visible in the shadow at N+1.
- The DONE=1 shadow is seen at N+1, so the state is SETTLE from N+2. The verdict appears at N+2+SETTLE_CYCLES.
- If done and timeout conditions hold in the same cycle, done wins.
- A write to DONE_REG with a value other than 1 keeps the state in RUN.
- A write of 1 to DONE_REG that lands while in SETTLE has no further effect.

## Configuration
- `RISCV_TEST_MONITOR_TIMEOUT_EN` defined: the watchdog is active and the TIMEOUT state is reachable.
- Undefined: the comparator is removed, `timeout_o` is tied to 0, and RUN only exits on done. `cycle_cnt` still counts.

## Structure
- Package `riscv_test_pkg` holds the state enum `test_mon_state_t` and the default register-index constants (`TEST_DONE_REG`, `TEST_RESULT_REG`, `TEST_NUM_REG`).
- One sub-module, `test_mon_shadow`: a single-register snooper that takes a register index parameter and resolves the priority among NUM_WB ports. It is instantiated three times.

## Test plan
- Pass case:
  - NUM_WB=1. Start, write x3=2, then x27=1, then x26=1 in cycle 10.
  - Required: `done_o`/`pass_o` rise at cycle 17, `testnum_o`=2, `fail_o`=0.
- Fail case:
  - Write x27=0, then x26=1, with x3=5.
  - Required: `fail_o`=1, `testnum_o`=5.
- Late result:
  - Write x26=1, then x27=1 two cycles later, within the settle window.
  - Required: `pass_o`=1.
- Port priority:
  - NUM_WB=2. In the same cycle, port0 writes x27=1 and port1 writes x27=0, followed by done.
  - Required: `fail_o`=1.
  - Also, both `retire_i` bits high for 4 cycles gives `instret_o`≥8.
- Timeout (macro defined, TIMEOUT_CYCLES=50):
  - Start and never write x26.
  - Required: `timeout_o`=1 with `cycle_cnt_o`=50.
  - Asserting `start_i` then re-arms, and the outputs are 0 on the next cycle.
- Reset mid-run:
  - Assert `rst` in SETTLE.
  - Required: all outputs 0 and the state IDLE on the next cycle.
  - A later `start_i` followed by a clean pass sequence passes.
